// File: rtl/shift_sequencer_if.sv
// Handshake bundle for shift_sequencer: two requester channels, one result
// channel and the busy flag. The slave modport is the sequencer's view; the
// master modport is the view of whatever drives requests and takes results.
interface shift_sequencer_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic [2:0] req0_op;
  logic [2:0] req0_amt;

  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic [2:0] req1_op;
  logic [2:0] req1_amt;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_id;

  logic       busy;

  modport slave (
    input  req0_valid, req0_data, req0_op, req0_amt,
    input  req1_valid, req1_data, req1_op, req1_amt,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id,
    output busy
  );

  modport master (
    output req0_valid, req0_data, req0_op, req0_amt,
    output req1_valid, req1_data, req1_op, req1_amt,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id,
    input  busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Two-requester multi-step shift sequencer. A round-robin arbiter accepts one
// operation at a time in IDLE, RUN applies one single-bit step per cycle for
// amt cycles, and DONE presents the 8-bit result until the consumer takes it.
module shift_sequencer (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] work_reg,  work_next;
  logic [2:0] op_reg,    op_next;
  logic [2:0] cnt_reg,   cnt_next;
  logic       id_reg,    id_next;
  // Index of the requester granted most recently; a tie goes to the other one.
  logic       last_reg,  last_next;

  logic       grant;
  logic       accept;
  logic [7:0] sel_data;
  logic [2:0] sel_op;
  logic [2:0] sel_amt;

  // One single-bit step of the selected operation on an 8-bit operand.
  function automatic logic [7:0] step(input logic [7:0] d, input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'b000:  r = {d[6:0], 1'b0};
      3'b001:  r = {1'b0, d[7:1]};
      3'b010:  r = {d[6:0], d[7]};
      3'b011:  r = {d[0], d[7:1]};
      3'b100:  r = {d[7], d[7:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Round-robin choice between the valid requesters, from valids and pointer only.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_reg;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.req0_ready = !rst && (state_reg == IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = !rst && (state_reg == IDLE) && bus.req1_valid &&  grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign sel_data = grant ? bus.req1_data : bus.req0_data;
  assign sel_op   = grant ? bus.req1_op   : bus.req0_op;
  assign sel_amt  = grant ? bus.req1_amt  : bus.req0_amt;

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    id_next    = id_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          work_next  = sel_data;
          op_next    = sel_op;
          cnt_next   = sel_amt;
          id_next    = grant;
          last_next  = grant;
          state_next = (sel_amt == 3'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        work_next = step(work_reg, op_reg);
        cnt_next  = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation and points the arbiter at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      work_reg  <= 8'h00;
      op_reg    <= 3'd0;
      cnt_reg   <= 3'd0;
      id_reg    <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
      id_reg    <= id_next;
      last_reg  <= last_next;
    end
  end

  assign bus.res_valid = (state_reg == DONE);
  assign bus.res_data  = work_reg;
  assign bus.res_id    = id_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset state, single-requester operations
// with hand-computed results and latency, round-robin order, result stall and
// reset abort.
module tb_shift_sequencer;

  logic clk;
  logic rst;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic v, input logic [7:0] d,
                           input logic [2:0] op, input logic [2:0] amt);
    if (!id) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_op = op; bus.req0_amt = amt;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_op = op; bus.req1_amt = amt;
    end
  endtask

  // One operation from a single requester; checks ready, latency, data and id.
  task automatic do_op(input string tag, input logic id, input logic [7:0] d,
                       input logic [2:0] op, input logic [2:0] amt,
                       input logic [7:0] exp_d);
    int  lat;
    bit  seen;
    @(negedge clk);
    bus.res_ready = 1'b1;
    drive_req(id, 1'b1, d, op, amt);
    #1;
    check({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.res_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, lat, 32'(amt) + 1);
    check({tag, "_data"}, bus.res_data, exp_d);
    check({tag, "_id"}, bus.res_id, id);
    $display("op %s: req%0d data=%02h op=%03b amt=%0d -> res=%02h id=%0d lat=%0d",
             tag, id, d, op, amt, bus.res_data, bus.res_id, lat);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  int  k;
  int  n_rdy;
  bit  prev_acc;
  bit  seen;
  bit  bad;
  logic exp_id;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus.res_ready = 1'b1;
    // Both requesters valid from reset: pass-through, amt 0.
    drive_req(1'b0, 1'b1, 8'h11, 3'b101, 3'd0);
    drive_req(1'b1, 1'b1, 8'h22, 3'b101, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_res_data", bus.res_data, 8'h00);
    check("rst_res_id", bus.res_id, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    rst = 1'b0;

    // Round-robin grant order with both valid and res_ready tied high.
    k = 0;
    prev_acc = 1'b0;
    exp_id = 1'b0;
    for (int i = 0; i < 30 && k < 4; i++) begin
      #1;
      n_rdy = int'(bus.req0_ready) + int'(bus.req1_ready);
      if (prev_acc) check("rr_pulse", n_rdy, 0);
      if (bus.res_valid) begin
        check("rr_res_id", bus.res_id, exp_id);
        check("rr_res_data", bus.res_data, exp_id ? 8'h22 : 8'h11);
      end
      if (n_rdy > 0) begin
        check("rr_onehot", n_rdy, 1);
        check("rr_order", bus.req1_ready, k % 2);
        $display("rr grant %0d -> req%0d", k, bus.req1_ready);
        exp_id = bus.req1_ready;
        k++;
      end
      prev_acc = (n_rdy > 0);
      if (k < 4) @(negedge clk);
    end
    check("rr_count", k, 4);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Directed single-requester operations.
    do_op("rotl3", 1'b0, 8'hB5, 3'b010, 3'd3, 8'hAD);
    do_op("asr2",  1'b1, 8'hB5, 3'b100, 3'd2, 8'hED);
    do_op("shl1",  1'b1, 8'hB5, 3'b000, 3'd1, 8'h6A);
    do_op("shr4",  1'b1, 8'hB5, 3'b001, 3'd4, 8'h0B);
    do_op("amt0",  1'b0, 8'h3C, 3'b011, 3'd0, 8'h3C);
    do_op("pass5", 1'b0, 8'h3C, 3'b111, 3'd5, 8'h3C);
    do_op("ror2",  1'b1, 8'h3C, 3'b011, 3'd2, 8'h0F);
    do_op("shl7",  1'b0, 8'hFF, 3'b000, 3'd7, 8'h80);

    // Result stalled in DONE for 5 cycles with both requesters valid.
    @(negedge clk);
    bus.res_ready = 1'b0;
    drive_req(1'b0, 1'b1, 8'h3C, 3'b000, 3'd1);
    #1;
    check("stall_ready0", bus.req0_ready, 1);
    @(posedge clk);
    #1;
    drive_req(1'b1, 1'b1, 8'h55, 3'b000, 3'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    check("stall_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_res_valid", bus.res_valid, 1);
      check("stall_res_data", bus.res_data, 8'h78);
      check("stall_res_id", bus.res_id, 0);
      check("stall_ready0", bus.req0_ready, 0);
      check("stall_ready1", bus.req1_ready, 0);
      check("stall_busy", bus.busy, 1);
    end
    $display("stall: res=%02h held 5 cycles", bus.res_data);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_next_ready1", bus.req1_ready, 1);
    check("stall_next_ready0", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the second RUN cycle of an amt-7 operation from requester 0.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 8'h81, 3'b000, 3'd7);
    #1;
    check("abort_ready0", bus.req0_ready, 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_run", bus.busy, 1);
    rst = 1'b1;
    drive_req(1'b0, 1'b1, 8'h01, 3'b101, 3'd0);
    drive_req(1'b1, 1'b1, 8'h02, 3'b101, 3'd0);
    #1;
    check("abort_rst_ready0", bus.req0_ready, 0);
    check("abort_rst_ready1", bus.req1_ready, 0);
    @(posedge clk);
    #1;
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_res_data", bus.res_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_tie_ready0", bus.req0_ready, 1);
    check("abort_tie_ready1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) bad = 1'b1;
    end
    check("abort_no_result", bad, 0);
    $display("abort: reset in RUN, tie granted to req0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
